// File: rtl/bfloat_div.sv
// bfloat_div -- multi-cycle bfloat16 divider (out = a / b).
//
// Ports:
//   clk    in   1   clock, rising edge
//   rst    in   1   asynchronous active-high reset
//   start  in   1   request, sampled only in IDLE
//   a      in  16   dividend {sign, exp[7:0] bias 127, man[6:0]}
//   b      in  16   divisor, same format
//   out    out 16   registered quotient, valid while done is high and held after
//   busy   out  1   high whenever the FSM is not IDLE
//   done   out  1   one-cycle pulse marking a fresh out/flags
//   flags  out  4   registered {invalid, divzero, overflow, underflow}
//
// Build option: define BFLOAT_DIV_RNE_EN to round to nearest-even in NORM;
// without it the mantissa is truncated. Cycle timing is the same either way.
//
// Normal operands: IDLE -> DIV (10 cycles, one restoring-division quotient bit
// per cycle) -> NORM -> DONE -> IDLE. Special operands (NaN, Inf, zero; exp==0
// is flushed to zero) go IDLE -> DONE directly.
module bfloat_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out,
  output logic        busy,
  output logic        done,
  output logic [3:0]  flags
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t             state;
  logic [3:0]         count;
  logic [9:0]         quo;      // quo[9] is the integer bit, quo[8:0] fraction
  logic [9:0]         rem;      // partial remainder, always < 2*divisor
  logic [7:0]         divisor;
  logic signed [9:0]  exp;
  logic               sign;

  // ---------------- operand classification (live inputs, used in IDLE) ----
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, special;
  logic [15:0] spec_out;
  logic [3:0]  spec_flags;

  assign a_zero  = (a[14:7] == 8'h00);
  assign b_zero  = (b[14:7] == 8'h00);
  assign a_inf   = (&a[14:7]) & ~(|a[6:0]);
  assign b_inf   = (&b[14:7]) & ~(|b[6:0]);
  assign a_nan   = (&a[14:7]) & (|a[6:0]);
  assign b_nan   = (&b[14:7]) & (|b[6:0]);
  assign special = a_zero | b_zero | a_inf | b_inf | a_nan | b_nan;

  always_comb begin
    spec_out   = {a[15] ^ b[15], 15'h0000};
    spec_flags = 4'b0000;
    if (a_nan | b_nan | (a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_out   = 16'h7FC0;
      spec_flags = 4'b1000;
    end else if (a_inf) begin
      // Inf divided by anything finite (zero included) stays Inf, no exception.
      spec_out = {a[15] ^ b[15], 8'hFF, 7'h00};
    end else if (b_zero) begin
      spec_out   = {a[15] ^ b[15], 8'hFF, 7'h00};
      spec_flags = 4'b0100;
    end
    // remaining cases (0/finite, 0/Inf, finite/Inf) keep the signed zero
  end

  // ---------------- normalisation and rounding (used in NORM) -------------
  logic [6:0]        man_n;
  logic              guard_bit, round_bit, sticky_bit;
  logic signed [9:0] exp_n, exp_r;
  logic [7:0]        man_r;     // bit 7 is the rounding carry-out
  logic [15:0]       norm_out;
  logic [3:0]        norm_flags;

  always_comb begin
    if (quo[9]) begin
      man_n     = quo[8:2];
      guard_bit = quo[1];
      round_bit = quo[0];
      exp_n     = exp;
    end else begin
      // quotient in [0.5,1): shift left once, no bit left below the guard
      man_n     = quo[7:1];
      guard_bit = quo[0];
      round_bit = 1'b0;
      exp_n     = exp - 10'sd1;
    end
    sticky_bit = |rem;
    man_r      = {1'b0, man_n};
`ifdef BFLOAT_DIV_RNE_EN
    if (guard_bit & (round_bit | sticky_bit | man_n[0]))
      man_r = man_r + 8'd1;
`endif
    exp_r = exp_n + $signed({9'b0, man_r[7]});

    norm_flags = 4'b0000;
    if (exp_r >= 10'sd255) begin
      norm_out   = {sign, 8'hFF, 7'h00};
      norm_flags = 4'b0010;
    end else if (exp_r <= 10'sd0) begin
      norm_out   = {sign, 15'h0000};
      norm_flags = 4'b0001;
    end else begin
      norm_out = {sign, exp_r[7:0], man_r[6:0]};
    end
  end

`ifndef BFLOAT_DIV_RNE_EN
  // Rounding bits only matter in the round-to-nearest-even build.
  logic unused_round_bits;
  assign unused_round_bits = guard_bit ^ round_bit ^ sticky_bit;
`endif

  // ---------------- division step ----------------------------------------
  logic [9:0] rem_sub;
  logic       rem_ge;
  assign rem_ge  = (rem >= {2'b00, divisor});
  assign rem_sub = rem - {2'b00, divisor};

  // ---------------- FSM ---------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= 4'd0;
      quo     <= 10'd0;
      rem     <= 10'd0;
      divisor <= 8'd0;
      exp     <= 10'sd0;
      sign    <= 1'b0;
      out     <= 16'h0000;
      flags   <= 4'h0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sign <= a[15] ^ b[15];
            if (special) begin
              out   <= spec_out;
              flags <= spec_flags;
              state <= DONE;
            end else begin
              rem     <= {3'b001, a[6:0]};
              divisor <= {1'b1, b[6:0]};
              exp     <= $signed({2'b00, a[14:7]}) - $signed({2'b00, b[14:7]}) + 10'sd127;
              quo     <= 10'd0;
              count   <= 4'd0;
              state   <= DIV;
            end
          end
        end
        DIV: begin
          if (rem_ge) begin
            quo <= {quo[8:0], 1'b1};
            rem <= {rem_sub[8:0], 1'b0};
          end else begin
            quo <= {quo[8:0], 1'b0};
            rem <= {rem[8:0], 1'b0};
          end
          count <= count + 4'd1;
          if (count == 4'd9)
            state <= NORM;
        end
        NORM: begin
          out   <= norm_out;
          flags <= norm_flags;
          state <= DONE;
        end
        default: state <= IDLE;  // DONE
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
